// File: rtl/flash_reader_if.sv
// Signal bundle between flash_reader, its clients (request/data stream) and the SPI engine.
// The client side drives start/addr/len and the engine returns spiQ; the reader drives the rest.
interface flash_reader_if #(
    parameter int unsigned LW = 16
);
    logic          start;
    logic [23:0]   addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          dataStb;
    logic [7:0]    dataQ;
    logic [LW-1:0] dataA;
    logic          cs;
    logic          spiTx;
    logic          spiRx;
    logic [7:0]    spiD;
    logic [7:0]    spiQ;

    modport master (
        output start, addr, len, spiQ,
        input  busy, done, dataStb, dataQ, dataA, cs, spiTx, spiRx, spiD
    );

    modport slave (
        input  start, addr, len, spiQ,
        output busy, done, dataStb, dataQ, dataA, cs, spiTx, spiRx, spiD
    );
endinterface

// File: rtl/flash_reader.sv
// SPI flash READ (0x03) sequencer: command, 24-bit address, then LEN received bytes streamed out
// as single-clock strobes. All phase timing counts ce ticks.
module flash_reader #(
    parameter int unsigned BYTE_TICKS = 16,
    parameter int unsigned CS_TICKS   = 2,
    parameter int unsigned LW         = 16
) (
    input logic           clock,
    input logic           reset,
    input logic           ce,
    flash_reader_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StCsl, StCmd, StA2, StA1, StA0, StData, StEnd} state_e;

    localparam int unsigned TMax = (BYTE_TICKS > CS_TICKS) ? BYTE_TICKS : CS_TICKS;
    localparam int unsigned TW   = $clog2(TMax);
    localparam logic [TW-1:0] TLastByte = TW'(BYTE_TICKS - 1);
    localparam logic [TW-1:0] TLastCs   = TW'(CS_TICKS - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [23:0]   addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          stb_q, stb_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [LW-1:0] offs_q, offs_d;
    logic          cs_q, cs_d;
    logic          tx_q, tx_d;
    logic          rx_q, rx_d;
    logic [7:0]    spid_q, spid_d;

    logic [7:0]    phase_byte;
    state_e        phase_next;

    always_comb begin
        phase_byte = 8'h03;
        phase_next = StA2;
        case (state_q)
            StA2:    begin phase_byte = addr_q[23:16]; phase_next = StA1;   end
            StA1:    begin phase_byte = addr_q[15:8];  phase_next = StA0;   end
            StA0:    begin phase_byte = addr_q[7:0];   phase_next = StData; end
            default: begin phase_byte = 8'h03;         phase_next = StA2;   end
        endcase
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        stb_d   = 1'b0;
        rdata_d = rdata_q;
        offs_d  = offs_q;
        cs_d    = cs_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        spid_d  = spid_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d  = bus.addr;
                    len_d   = bus.len;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    t_d     = '0;
                    state_d = (bus.len == '0) ? StEnd : StCsl;
                end
            end
            StCsl: begin
                if (ce) begin
                    cs_d = 1'b0;
                    if (t_q == TLastCs) begin
                        state_d = StCmd;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            StCmd, StA2, StA1, StA0: begin
                if (ce) begin
                    if (t_q == '0) begin
                        tx_d   = 1'b1;
                        spid_d = phase_byte;
                    end else if (t_q == TW'(1)) begin
                        tx_d = 1'b0;
                    end
                    if (t_q == TLastByte) begin
                        state_d = phase_next;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            StData: begin
                if (ce) begin
                    if (t_q == '0) begin
                        rx_d   = 1'b1;
                        spid_d = 8'h00;
                    end else if (t_q == TW'(1)) begin
                        rx_d = 1'b0;
                    end
                    if (t_q == TLastByte) begin
                        rdata_d = bus.spiQ;
                        offs_d  = idx_q;
                        stb_d   = 1'b1;
                        idx_d   = idx_q + LW'(1);
                        t_d     = '0;
                        if (idx_q == len_q - LW'(1)) state_d = StEnd;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            StEnd: begin
                // A zero-length request finishes on the next clock without waiting for ce.
                if (ce || len_q == '0) begin
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            t_q     <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stb_q   <= 1'b0;
            rdata_q <= '0;
            offs_q  <= '0;
            cs_q    <= 1'b1;
            tx_q    <= 1'b0;
            rx_q    <= 1'b0;
            spid_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stb_q   <= stb_d;
            rdata_q <= rdata_d;
            offs_q  <= offs_d;
            cs_q    <= cs_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            spid_q  <= spid_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dataStb = stb_q;
    assign bus.dataQ   = rdata_q;
    assign bus.dataA   = offs_q;
    assign bus.cs      = cs_q;
    assign bus.spiTx   = tx_q;
    assign bus.spiRx   = rx_q;
    assign bus.spiD    = spid_q;

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: directed and randomized reads checked against a transaction-level model
// (expected command bytes, strobe list and cs-low duration computed from the transfer parameters).
module tb_flash_reader;

    localparam int unsigned B  = 16;
    localparam int unsigned CS = 2;
    localparam int unsigned LW = 16;

    logic clock = 1'b0;
    logic reset;
    logic ce = 1'b0;

    flash_reader_if #(.LW(LW)) bus ();

    flash_reader #(.BYTE_TICKS(B), .CS_TICKS(CS), .LW(LW)) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int unsigned ce_period = 16;
    int unsigned ce_cnt    = 0;

    logic [7:0]    q_vals[$];
    logic [7:0]    tx_log[$];
    logic [7:0]    stb_q[$];
    logic [LW-1:0] stb_a[$];
    int rx_cnt, stb_cnt, done_cnt, cs_clks, busy_clks, both_hi, first_stb_clks;
    logic prev_tx = 1'b0;
    logic prev_rx = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ce_loop();
        forever begin
            @(negedge clock);
            if (ce_cnt + 1 >= ce_period) begin
                ce_cnt = 0;
                ce = 1'b1;
            end else begin
                ce_cnt++;
                ce = 1'b0;
            end
        end
    endtask

    // Observes settled outputs each negedge and plays the SPI engine's returned bytes.
    task automatic monitor_loop();
        forever begin
            @(negedge clock);
            if (bus.spiTx && !prev_tx) tx_log.push_back(bus.spiD);
            if (bus.spiRx && !prev_rx) begin
                if (rx_cnt < q_vals.size()) bus.spiQ = q_vals[rx_cnt];
                rx_cnt++;
            end
            if (bus.spiTx && bus.spiRx) both_hi++;
            prev_tx = bus.spiTx;
            prev_rx = bus.spiRx;
            if (bus.dataStb) begin
                stb_q.push_back(bus.dataQ);
                stb_a.push_back(bus.dataA);
                if (stb_cnt == 0) first_stb_clks = cs_clks;
                stb_cnt++;
            end
            if (bus.done) done_cnt++;
            if (!bus.cs) cs_clks++;
            if (bus.busy) busy_clks++;
        end
    endtask

    task automatic clear_mon();
        tx_log.delete();
        stb_q.delete();
        stb_a.delete();
        rx_cnt = 0; stb_cnt = 0; done_cnt = 0; cs_clks = 0;
        busy_clks = 0; both_hi = 0; first_stb_clks = -1;
    endtask

    function automatic logic [31:0] tx_word();
        if (tx_log.size() != 4) return 32'hDEAD_0000 | 32'(tx_log.size());
        return {tx_log[0], tx_log[1], tx_log[2], tx_log[3]};
    endfunction

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clock);
    endtask

    // Full transfer with model checks; intrude issues a foreign start during the data phase.
    task automatic do_xfer(input string tag, input logic [23:0] a, input int n, input int per,
                           input bit intrude);
        int budget;
        ce_period = per;
        ce_cnt    = 0;
        clear_mon();
        @(negedge clock);
        bus.addr  = a;
        bus.len   = LW'(n);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        budget = (CS + (4 + n) * B + 4) * per + 20;
        if (intrude) begin
            for (int i = 0; i < budget && stb_cnt == 0; i++) @(negedge clock);
            bus.addr  = 24'h123456;
            bus.len   = LW'(2);
            bus.start = 1'b1;
            @(negedge clock);
            bus.start = 1'b0;
        end
        wait_done(budget);
        check({tag, " done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (3 * per + 4) @(negedge clock);
        check({tag, " tx_bytes"}, tx_word(), {8'h03, a});
        check({tag, " rx_count"}, 32'(rx_cnt), 32'(n));
        check({tag, " stb_count"}, 32'(stb_cnt), 32'(n));
        for (int j = 0; j < n && j < stb_q.size(); j++) begin
            check({tag, " dataQ"}, 32'(stb_q[j]), 32'(q_vals[j]));
            check({tag, " dataA"}, 32'(stb_a[j]), 32'(j));
        end
        check({tag, " cs_low_clks"}, 32'(cs_clks), 32'((CS + (4 + n) * B) * per));
        check({tag, " first_stb_clks"}, 32'(first_stb_clks), 32'((CS + 5 * B - 1) * per));
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " tx_rx_overlap"}, 32'(both_hi), 32'd0);
        check({tag, " idle_after"}, {30'd0, bus.cs, bus.busy}, 32'b10);
        check({tag, " dataQ_held"}, 32'(bus.dataQ), 32'(q_vals[n-1]));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.addr  = '0;
        bus.len   = '0;
        bus.spiQ  = 8'h00;
        reset     = 1'b0;
        clear_mon();
        fork
            ce_loop();
            monitor_loop();
        join_none

        // Reset hold with start asserted.
        bus.start = 1'b1;
        bus.len   = LW'(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("reset_hold ctl", {26'd0, bus.cs, bus.busy, bus.spiTx, bus.spiRx, bus.done,
                  bus.dataStb}, 32'b100000);
        end
        check("reset_hold data", {8'd0, bus.spiD, bus.dataQ, bus.dataA[7:0]}, 32'd0);
        bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        q_vals = '{8'hA5};
        do_xfer("single", 24'h00704D, 1, 16, 1'b0);

        q_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_xfer("burst", 24'h0B0000, 4, 16, 1'b0);

        // Zero length: done two clocks after start, busy for exactly one clock.
        clear_mon();
        @(negedge clock);
        bus.addr  = 24'hABCDEF;
        bus.len   = '0;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("zero busy_first", {30'd0, bus.busy, bus.done}, 32'b10);
        @(negedge clock);
        check("zero done_second", {30'd0, bus.busy, bus.done}, 32'b01);
        repeat (40) @(negedge clock);
        check("zero busy_clks", 32'(busy_clks), 32'd1);
        check("zero done_count", 32'(done_cnt), 32'd1);
        check("zero no_cs", 32'(cs_clks), 32'd0);
        check("zero no_tx", 32'(tx_log.size()), 32'd0);

        q_vals = '{8'h5A, 8'hC3, 8'h7E};
        do_xfer("busy_ignore", 24'h0F00F0, 3, 4, 1'b1);
        repeat (60) @(negedge clock);
        check("busy_ignore no_restart", 32'(tx_log.size()), 32'd4);

        // Reset during the A1 phase.
        clear_mon();
        q_vals = '{8'h99, 8'h98};
        ce_period = 2;
        ce_cnt    = 0;
        @(negedge clock);
        bus.addr  = 24'h654321;
        bus.len   = LW'(2);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int i = 0; i < 400 && tx_log.size() < 3; i++) @(negedge clock);
        check("midreset reached_a1", 32'(tx_log.size()), 32'd3);
        reset = 1'b0;
        @(negedge clock);
        check("midreset idle", {30'd0, bus.cs, bus.busy}, 32'b10);
        reset = 1'b1;
        repeat (200) @(negedge clock);
        check("midreset no_done", 32'(done_cnt), 32'd0);
        check("midreset no_stb", 32'(stb_cnt), 32'd0);

        q_vals = '{8'h0F, 8'hF0};
        do_xfer("after_reset", 24'h010203, 2, 3, 1'b0);

        // Randomized transfers.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            q_vals.delete();
            for (int j = 0; j < n; j++) q_vals.push_back(8'($urandom));
            do_xfer("random", 24'($urandom), n, int'($urandom_range(1, 4)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/flash_reader.md
Name: flash_reader

Overview:
- Sequencer for the SPI flash master (`spi` engine: tx/rx strobes, d/q bytes, 8-bit Q).
- On request it issues a standard READ (0x03) with a 24-bit address, then streams LEN data bytes out as single-clock strobes.
- It replaces the hand-coded boot-time flash slot table in the top level. It sits between the top-level clients (BIOS-option fetch, ROM/loader copy into SDRAM) and the shared flash SPI pins.

Parameters:
- BYTE_TICKS, 16, ce ticks allotted per SPI byte phase (must be >=4; ≥ the spi engine byte time in ce ticks).
- CS_TICKS, 2, ce ticks between cs falling and the command phase starting (>=1).
- LW, 16, width of the length/offset fields.

Ports:
- clock, in, 1, system clock (56 MHz).
- reset, in, 1, synchronous, active-low.
- ce, in, 1, sequencing clock enable (pe3M5-class pulse); all phase timing counts ce ticks.
- start, in, 1, request; accepted on any clock while busy=0.
- addr, in, 24, flash byte address; latched at accept.
- len, in, LW, number of data bytes; latched at accept.
- busy, out, 1, high from the clock after accept until done.
- done, out, 1, one-clock pulse at end of transfer.
- dataStb, out, 1, one-clock pulse per received byte.
- dataQ, out, 8, received byte; valid while dataStb=1, held until next strobe.
- dataA, out, LW, byte offset (0..len-1) of dataQ.
- cs, out, 1, flash chip select, active-low.
- spiTx, out, 1, transmit-start strobe to spi engine.
- spiRx, out, 1, receive-start strobe to spi engine.
- spiD, out, 8, byte to transmit.
- spiQ, in, 8, byte received by spi engine.

Behaviour:
- Reset (reset=0 at a clock edge; it takes priority over everything):
  - state IDLE; cs=1, busy=0, done=0, dataStb=0, spiTx=0, spiRx=0, spiD=0, dataQ=0, dataA=0.
  - This applies mid-transfer too: cs rises on that edge, no further strobes, and no done pulse.
- Accept:
  - In IDLE with start=1: latch addr and len, and set busy=1 next clock.
  - If len=0: no flash activity; done pulses and busy returns to 0 on the following clock.
  - start while busy=1 is ignored (not queued).
- States: IDLE -> CSL -> CMD -> A2 -> A1 -> A0 -> DATA -> END -> IDLE.
- Tick counter: a phase tick counter t counts ce ticks within each state and resets to 0 on every state change.
- CSL:
  - The first ce tick after accept drives cs=0.
  - Remain CS_TICKS ticks, then go to CMD.
- CMD/A2/A1/A0 phases, each BYTE_TICKS ticks:
  - At t=0: spiD = 0x03 / addr[23:16] / addr[15:8] / addr[7:0] respectively, and spiTx=1.
  - At t=1: spiTx=0.
  - spiD is held for the whole phase.
- DATA phase, repeated len times, each BYTE_TICKS ticks:
  - t=0: spiRx=1. t=1: spiRx=0. spiD=0x00 throughout.
  - t=BYTE_TICKS-1: dataQ<=spiQ, dataA<=byte index, and dataStb=1 for exactly one clock (the ce clock).
  - The byte index increments after each strobe. After strobe index len-1, go to END.
- END: on the next ce tick cs=1, done=1 for one clock, busy=0 that same clock, then state IDLE.
- Strobe widths:
  - spiTx/spiRx are asserted on a ce clock and dropped on the next ce clock. They are never both high.
  - Outside phases t=0 they are low.
- Timing:
  - cs low duration = CS_TICKS + (4+len)*BYTE_TICKS ce ticks.
  - First dataStb at tick CS_TICKS + 5*BYTE_TICKS - 1 after cs falls.
- Length arithmetic:
  - len max = 2^LW-1; the index counter is LW bits and never wraps within a transfer.
  - Address is not incremented by the block (flash auto-increments).
- Between ce ticks all outputs hold, except the one-clock pulses done/dataStb, which clear on the next clock.
- A new start is accepted on the clock after done.

Test Plan:
- Reset hold: reset=0 for 5 clocks with start=1 -> cs=1, busy=0, no spiTx/spiRx/done/dataStb.
- Single read:
  - Stimulus: addr=0x00704D, len=1, spiQ=0xA5, ce every 16 clocks, defaults.
  - Required response:
    - spiTx bytes in order 0x03,0x00,0x70,0x4D.
    - One spiRx, then dataStb with dataQ=0xA5, dataA=0.
    - cs low exactly 2+5*16=82 ticks, then done one clock.
- Burst: addr=0x0B0000, len=4, spiQ sequence 0x11,0x22,0x33,0x44 -> four dataStb with dataA=0..3 and matching dataQ; cs low 2+8*16=130 ticks; exactly one done.
- Zero length: start with len=0 -> cs never falls, no spiTx; done pulses 2 clocks after start; busy high exactly 1 clock.
- Busy ignore: second start with addr=0x123456 during the first transfer's DATA phase -> no effect; transferred bytes and addresses are those of the first request only.
- Reset mid-transfer:
  - Stimulus: assert reset during A1 phase.
  - Required response: cs=1 and busy=0 next clock, no done pulse.
  - Follow-up: a new start afterwards begins cleanly with 0x03.
